ethernet_udp_receive: RTL and testbench

MII-side UDP/IPv4 receiver. It is the receive counterpart of ethernet_udp_transmit.
- Samples the PHY receive nibbles, strips the preamble and SFD, and assembles bytes in low-nibble-first order.
- Checks the Ethernet, IPv4 and UDP headers against the local addresses.
- Streams the UDP payload bytes out with first/last markers.
- Reports a per-frame verdict that includes an FCS (CRC-32) check.
- Runs directly in the PHY receive clock domain (25 MHz). Downstream CDC/FIFO is outside this block.

---
 rtl/ethernet_udp_receive.sv | 238 +++++++++++++++++++++++
 tb/tb_ethernet_udp_receive.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_udp_receive.sv
// MII receiver for UDP/IPv4: strips preamble/SFD, validates Ethernet/IPv4/UDP headers,
// streams the UDP payload and reports a per-frame verdict including the FCS check.
module ethernet_udp_receive #(
    parameter int unsigned MAX_DATA_BYTES   = 480,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rx_d,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port
);

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, DROP
    } state_t;

    state_t r_state, w_next;

    logic        r_phase;
    logic [3:0]  r_lo;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic        r_uc_ok, r_bc_ok;
    logic [47:0] r_smac;
    logic [31:0] r_sip;
    logic [15:0] r_sport;
    logic [15:0] r_len;
    logic [15:0] r_n;
    logic [15:0] r_pay_idx;
    logic        r_hdr_done, r_emitted, r_err;

    logic [7:0]  w_byte, w_ref;
    logic        w_in_frame, w_byte_done, w_sfd, w_frame_end;
    logic        w_is_mac, w_is_fix, w_uc_next, w_bc_next, w_hdr_fail;
    logic [15:0] w_len;
    logic [31:0] w_crc_next;
    logic        w_pay_last, w_ok;

    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    assign w_byte      = {rx_d, r_lo};
    assign w_in_frame  = (r_state == HEADER) || (r_state == PAYLOAD) ||
                         (r_state == TRAILER) || (r_state == DROP);
    assign w_byte_done = w_in_frame && rx_dv && r_phase;
    assign w_sfd       = (r_state == PREAMBLE) && rx_dv && (rx_d == 4'hD);
    assign w_frame_end = w_in_frame && !rx_dv;
    assign w_crc_next  = f_crc8(r_crc, w_byte);
    assign w_pay_last  = (r_pay_idx == r_n - 16'd1);
    assign w_ok        = r_hdr_done && r_emitted && !r_err && !r_phase &&
                         ({5'd0, r_cnt} >= 16'd46 + r_n) && (r_cnt >= 11'd64) &&
                         (r_crc == 32'hDEBB20E3);

    // Expected value for the header byte at the current offset
    always_comb begin
        w_ref    = '0;
        w_is_mac = 1'b0;
        w_is_fix = 1'b0;
        case (r_cnt)
            11'd0:  begin w_ref = local_mac[47:40]; w_is_mac = 1'b1; end
            11'd1:  begin w_ref = local_mac[39:32]; w_is_mac = 1'b1; end
            11'd2:  begin w_ref = local_mac[31:24]; w_is_mac = 1'b1; end
            11'd3:  begin w_ref = local_mac[23:16]; w_is_mac = 1'b1; end
            11'd4:  begin w_ref = local_mac[15:8];  w_is_mac = 1'b1; end
            11'd5:  begin w_ref = local_mac[7:0];   w_is_mac = 1'b1; end
            11'd12: begin w_ref = 8'h08;            w_is_fix = 1'b1; end
            11'd13: begin w_ref = 8'h00;            w_is_fix = 1'b1; end
            11'd14: begin w_ref = 8'h45;            w_is_fix = 1'b1; end
            11'd23: begin w_ref = 8'h11;            w_is_fix = 1'b1; end
            11'd30: begin w_ref = local_ip[31:24];  w_is_fix = 1'b1; end
            11'd31: begin w_ref = local_ip[23:16];  w_is_fix = 1'b1; end
            11'd32: begin w_ref = local_ip[15:8];   w_is_fix = 1'b1; end
            11'd33: begin w_ref = local_ip[7:0];    w_is_fix = 1'b1; end
            11'd36: begin w_ref = local_port[15:8]; w_is_fix = 1'b1; end
            11'd37: begin w_ref = local_port[7:0];  w_is_fix = 1'b1; end
            default: ;
        endcase
        // Unicast and broadcast matches are tracked separately so mixed addresses fail
        w_uc_next  = r_uc_ok && (w_byte == w_ref);
        w_bc_next  = r_bc_ok && ACCEPT_BROADCAST && (w_byte == 8'hFF);
        w_len      = {r_len[7:0], w_byte};
        w_hdr_fail = 1'b0;
        if (w_is_mac)
            w_hdr_fail = !(w_uc_next || w_bc_next);
        else if (w_is_fix)
            w_hdr_fail = (w_byte != w_ref);
        else if (r_cnt == 11'd39)
            w_hdr_fail = (w_len < 16'd8) || (w_len > 16'(MAX_DATA_BYTES + 8));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= WAIT_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_IDLE: if (!rx_dv) w_next = IDLE;
            // Activity not starting with a preamble nibble is mid-frame; wait it out
            IDLE:      if (rx_dv) w_next = (rx_d == 4'h5) ? PREAMBLE : WAIT_IDLE;
            PREAMBLE: begin
                if (!rx_dv)              w_next = WAIT_IDLE;
                else if (rx_d == 4'hD)   w_next = HEADER;
                else if (rx_d != 4'h5)   w_next = WAIT_IDLE;
            end
            HEADER: begin
                if (!rx_dv)              w_next = IDLE;
                else if (rx_er)          w_next = DROP;
                else if (w_byte_done) begin
                    if (w_hdr_fail)          w_next = DROP;
                    else if (r_cnt == 11'd41) w_next = (r_len == 16'd8) ? TRAILER : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!rx_dv)                        w_next = IDLE;
                else if (rx_er)                    w_next = DROP;
                else if (w_byte_done && w_pay_last) w_next = TRAILER;
            end
            TRAILER: begin
                if (!rx_dv)      w_next = IDLE;
                else if (rx_er)  w_next = DROP;
            end
            DROP:      if (!rx_dv) w_next = IDLE;
            default:   w_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            src_mac    <= '0;
            src_ip     <= '0;
            src_port   <= '0;
            r_phase    <= 1'b0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_crc      <= '1;
            r_uc_ok    <= 1'b0;
            r_bc_ok    <= 1'b0;
            r_smac     <= '0;
            r_sip      <= '0;
            r_sport    <= '0;
            r_len      <= '0;
            r_n        <= '0;
            r_pay_idx  <= '0;
            r_hdr_done <= 1'b0;
            r_emitted  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;

            if (w_sfd) begin
                r_phase    <= 1'b0;
                r_cnt      <= '0;
                r_crc      <= '1;
                r_uc_ok    <= 1'b1;
                r_bc_ok    <= 1'b1;
                r_pay_idx  <= '0;
                r_hdr_done <= 1'b0;
                r_emitted  <= 1'b0;
                r_err      <= 1'b0;
            end

            if (w_in_frame && rx_dv) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_lo <= rx_d;
                if (rx_er)    r_err <= 1'b1;
            end

            if (w_byte_done) begin
                r_crc <= w_crc_next;
                if (r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
            end

            if (r_state == HEADER && w_byte_done && !rx_er) begin
                if (w_is_mac) begin
                    r_uc_ok <= w_uc_next;
                    r_bc_ok <= w_bc_next;
                end
                if (r_cnt >= 11'd6 && r_cnt <= 11'd11)  r_smac  <= {r_smac[39:0], w_byte};
                if (r_cnt >= 11'd26 && r_cnt <= 11'd29) r_sip   <= {r_sip[23:0], w_byte};
                if (r_cnt == 11'd34 || r_cnt == 11'd35) r_sport <= {r_sport[7:0], w_byte};
                if (r_cnt == 11'd38 || r_cnt == 11'd39) r_len   <= w_len;
                if (r_cnt == 11'd41) begin
                    src_mac    <= r_smac;
                    src_ip     <= r_sip;
                    src_port   <= r_sport;
                    r_hdr_done <= 1'b1;
                    r_n        <= r_len - 16'd8;
                    if (r_len == 16'd8) r_emitted <= 1'b1;
                end
            end

            if (r_state == PAYLOAD && w_byte_done && !rx_er) begin
                out_valid <= 1'b1;
                out_data  <= w_byte;
                out_first <= (r_pay_idx == 16'd0);
                out_last  <= w_pay_last;
                r_pay_idx <= r_pay_idx + 16'd1;
                if (w_pay_last) r_emitted <= 1'b1;
            end

            if (w_frame_end) begin
                frame_done <= 1'b1;
                frame_ok   <= w_ok;
            end
        end
    end

endmodule

// File: tb/tb_ethernet_udp_receive.sv
// Scoreboard bench for ethernet_udp_receive: directed frames push expected beats and
// verdicts; a negedge monitor pops and compares whenever the DUT presents an output.
module tb_ethernet_udp_receive;

    localparam logic [47:0] LMAC  = 48'h1a2b3c4d5e6f;
    localparam logic [31:0] LIP   = 32'h11223344;
    localparam logic [15:0] LPORT = 16'h1000;
    localparam logic [47:0] SMAC  = 48'haabbccddeeff;
    localparam logic [31:0] SIP   = 32'h55667788;
    localparam logic [15:0] SPORT = 16'h1000;

    logic        clk = 1'b0;
    logic        reset, rx_dv, rx_er;
    logic [3:0]  rx_d;
    logic        out_valid, out_first, out_last, frame_done, frame_ok;
    logic [7:0]  out_data;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;

    always #20 clk = ~clk;

    ethernet_udp_receive #(.MAX_DATA_BYTES(480), .ACCEPT_BROADCAST(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rx_d(rx_d),
        .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .frame_done(frame_done), .frame_ok(frame_ok),
        .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port)
    );

    typedef struct packed { logic [7:0] d; logic f; logic l; } beat_t;
    typedef struct packed { logic ok; logic [47:0] mac; logic [31:0] ip; logic [15:0] port; } verd_t;

    beat_t       exp_beats[$];
    verd_t       exp_verd[$];
    logic [7:0]  frm[$];
    logic [47:0] exp_smac = '0;
    logic [31:0] exp_sip  = '0;
    logic [15:0] exp_sport = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    beat_t       mb;
    verd_t       mv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_beats.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat: got data %h, expected no beat", out_data);
            end else begin
                mb = exp_beats.pop_front();
                chk("beat_data",  {56'd0, out_data},  {56'd0, mb.d});
                chk("beat_first", {63'd0, out_first}, {63'd0, mb.f});
                chk("beat_last",  {63'd0, out_last},  {63'd0, mb.l});
            end
        end
        if (!reset && frame_done) begin
            if (exp_verd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_frame_done: got frame_ok %b, expected no frame_done", frame_ok);
            end else begin
                mv = exp_verd.pop_front();
                chk("frame_ok", {63'd0, frame_ok}, {63'd0, mv.ok});
                chk("src_mac",  {16'd0, src_mac},  {16'd0, mv.mac});
                chk("src_ip",   {32'd0, src_ip},   {32'd0, mv.ip});
                chk("src_port", {48'd0, src_port}, {48'd0, mv.port});
            end
        end
    end

    // Frame: headers, payload 0x0F,0x0E,..., zero pad to 60 bytes, then FCS LSB first
    task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [15:0] ulen, input int npay);
        logic [31:0] c;
        logic [15:0] tot;
        frm.delete();
        tot = ulen + 16'd20;
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(SMAC[8*i +: 8]);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h45); frm.push_back(8'h00);
        frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
        for (int i = 0; i < 4; i++) frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(SIP[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[8*i +: 8]);
        frm.push_back(SPORT[15:8]); frm.push_back(SPORT[7:0]);
        frm.push_back(LPORT[15:8]); frm.push_back(LPORT[7:0]);
        frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < npay; i++) frm.push_back(8'(15 - i));
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (frm[k]) begin
            c = c ^ {24'd0, frm[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic exp_beats_push(input int nbeats, input int npay);
        for (int i = 0; i < nbeats; i++)
            exp_beats.push_back('{d: 8'(15 - i), f: (i == 0), l: (i == npay - 1)});
    endtask

    task automatic exp_verdict(input logic ok, input logic hdr_pass);
        if (hdr_pass) begin
            exp_smac = SMAC; exp_sip = SIP; exp_sport = SPORT;
        end
        exp_verd.push_back('{ok: ok, mac: exp_smac, ip: exp_sip, port: exp_sport});
    endtask

    task automatic nib(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv; rx_d = d; rx_er = er;
    endtask

    // er_byte: frame byte carrying rx_er; rst_byte: reset asserted on that byte's high nibble
    task automatic send(input int er_byte, input int bad_pre, input int rst_byte);
        logic [7:0] b;
        for (int i = 0; i < 15; i++) nib(1'b1, (bad_pre != 0 && i == 3) ? 4'h7 : 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            if (rst_byte >= 0 && i == rst_byte + 2) reset = 1'b0;
            nib(1'b1, b[3:0], i == er_byte);
            if (i == rst_byte) begin
                @(negedge clk);
                reset = 1'b1; rx_d = b[7:4];
                #1;
                exp_smac = '0; exp_sip = '0; exp_sport = '0;
                chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
                chk("rst_src_mac", {16'd0, src_mac}, {16'd0, exp_smac});
                chk("rst_src_ip",  {32'd0, src_ip},  {32'd0, exp_sip});
            end else begin
                nib(1'b1, b[7:4], i == er_byte);
            end
        end
        for (int i = 0; i < 12; i++) nib(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_d = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid",  {63'd0, out_valid},  64'd0);
        chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
        chk("reset_frame_ok",   {63'd0, frame_ok},   64'd0);
        chk("reset_src_mac",    {16'd0, src_mac},    64'd0);
        chk("reset_src_ip",     {32'd0, src_ip},     64'd0);
        chk("reset_src_port",   {48'd0, src_port},   64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 16-byte payload, good frame
        build(LMAC, LIP, 16'd24, 16); exp_beats_push(16, 16); exp_verdict(1'b1, 1'b1);
        send(-1, 0, -1);
        // wrong destination IP
        build(LMAC, 32'h11223345, 16'd24, 16); exp_verdict(1'b0, 1'b0);
        send(-1, 0, -1);
        // 3-byte payload padded, then same with FCS bit flipped
        build(LMAC, LIP, 16'd11, 3); exp_beats_push(3, 3); exp_verdict(1'b1, 1'b1);
        send(-1, 0, -1);
        frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
        exp_beats_push(3, 3); exp_verdict(1'b0, 1'b1);
        send(-1, 0, -1);
        // broadcast with empty payload; oversize UDP length
        build(48'hFFFFFFFFFFFF, LIP, 16'd8, 0); exp_verdict(1'b1, 1'b1);
        send(-1, 0, -1);
        build(LMAC, LIP, 16'h01F1, 0); exp_verdict(1'b0, 1'b0);
        send(-1, 0, -1);
        // rx_er on payload byte 5
        build(LMAC, LIP, 16'd24, 16); exp_beats_push(5, 16); exp_verdict(1'b0, 1'b1);
        send(47, 0, -1);
        // reset during payload byte 8: beats 0-7 only, no verdict, then a good frame
        build(LMAC, LIP, 16'd24, 16); exp_beats_push(8, 16);
        send(-1, 0, 50);
        build(LMAC, LIP, 16'd24, 16); exp_beats_push(16, 16); exp_verdict(1'b1, 1'b1);
        send(-1, 0, -1);
        // corrupted preamble ignored, following frame accepted
        build(LMAC, LIP, 16'd24, 16);
        send(-1, 1, -1);
        exp_beats_push(16, 16); exp_verdict(1'b1, 1'b1);
        send(-1, 0, -1);

        repeat (5) @(negedge clk);
        chk("beats_outstanding",    64'(exp_beats.size()), 64'd0);
        chk("verdicts_outstanding", 64'(exp_verd.size()),  64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
